// File: rtl/edge_pkg.sv
// Shared types for the edge-detection pipeline: window buffer FSM states
// and the 3x3 window bundle consumed by the Sobel stage.
package edge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } winbuf_state_t;

   localparam int PIX_W = 8;

   // [0]=top-left .. [8]=bottom-right, row-major
   typedef logic [8:0][PIX_W-1:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels, single port indexed by column.
// Read is combinational, so a same-cycle write lands after the read.
module line_buffer
   import edge_pkg::*;
#(
   parameter int BIT_PER_PIXEL = 8,
   parameter int MAX_WIDTH     = 64
) (
   input  logic                         clk,
   input  logic [$clog2(MAX_WIDTH)-1:0] addr,
   input  logic                         we,
   input  logic [BIT_PER_PIXEL-1:0]     wdata,
   output logic [BIT_PER_PIXEL-1:0]     rdata
);

   logic [BIT_PER_PIXEL-1:0] mem [MAX_WIDTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/sobel_window_buffer.sv
// Streams raster pixels in, emits every interior 3x3 window with its centre.
// Define WINBUF_OVERRUN_CHECK_EN to add the sticky overrun_err output.
module sobel_window_buffer
   import edge_pkg::*;
#(
   parameter int BIT_PER_PIXEL = 8,
   parameter int MAX_WIDTH     = 64,
   parameter int DIM_BITS      = 7
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          start,
   input  logic [DIM_BITS-1:0]           img_width,
   input  logic [DIM_BITS-1:0]           img_height,
   input  logic [BIT_PER_PIXEL-1:0]      pix_in,
   input  logic                          pix_valid,
   output logic                          pix_ready,
   output logic [8:0][BIT_PER_PIXEL-1:0] win_out,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [DIM_BITS-1:0]           win_row,
   output logic [DIM_BITS-1:0]           win_col,
   output logic                          frame_done,
   output logic                          busy
`ifdef WINBUF_OVERRUN_CHECK_EN
   ,
   output logic                          overrun_err
`endif
);

   localparam int AW = $clog2(MAX_WIDTH);

   typedef logic [BIT_PER_PIXEL-1:0] pix_t;

   winbuf_state_t state, state_nx;

   logic [DIM_BITS-1:0] width, height, row, col;
   pix_t                lb0_rd, lb1_rd;
   pix_t [1:0]          sr_top, sr_mid, sr_bot;
   logic                legal, take, last_pix, emit, row_start;

   assign legal = start
               && img_width  >= DIM_BITS'(3)
               && img_width  <= DIM_BITS'(MAX_WIDTH)
               && img_height >= DIM_BITS'(3);

   assign pix_ready = (state == RUN) && (!win_valid || win_ready);
   // a restarting start wins over a same-cycle pixel
   assign take      = pix_valid && pix_ready && !legal;
   assign last_pix  = (row == height - DIM_BITS'(1))
                   && (col == width - DIM_BITS'(1));
   assign row_start = (col == '0);
   assign emit      = take && row >= DIM_BITS'(2) && col >= DIM_BITS'(2);

   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

   line_buffer #(
      .BIT_PER_PIXEL(BIT_PER_PIXEL),
      .MAX_WIDTH    (MAX_WIDTH)
   ) linebuf0 (
      .clk  (clk),
      .addr (col[AW-1:0]),
      .we   (take),
      .wdata(pix_in),
      .rdata(lb0_rd)
   );

   line_buffer #(
      .BIT_PER_PIXEL(BIT_PER_PIXEL),
      .MAX_WIDTH    (MAX_WIDTH)
   ) linebuf1 (
      .clk  (clk),
      .addr (col[AW-1:0]),
      .we   (take),
      .wdata(lb0_rd),
      .rdata(lb1_rd)
   );

   always_comb begin
      state_nx = state;
      if (legal) begin
         state_nx = RUN;
      end else begin
         unique case (state)
            RUN:     if (take && last_pix) state_nx = FLUSH;
            FLUSH:   if (!win_valid || win_ready) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         width  <= '0;
         height <= '0;
         row    <= '0;
         col    <= '0;
      end else if (legal) begin
         width  <= img_width;
         height <= img_height;
         row    <= '0;
         col    <= '0;
      end else if (take) begin
         if (col == width - DIM_BITS'(1)) begin
            col <= '0;
            row <= row + DIM_BITS'(1);
         end else begin
            col <= col + DIM_BITS'(1);
         end
      end
   end

   // two older columns; the newest column comes straight from the buffers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr_top <= '0;
         sr_mid <= '0;
         sr_bot <= '0;
      end else if (take) begin
         sr_top <= {lb1_rd, row_start ? pix_t'(0) : sr_top[1]};
         sr_mid <= {lb0_rd, row_start ? pix_t'(0) : sr_mid[1]};
         sr_bot <= {pix_in, row_start ? pix_t'(0) : sr_bot[1]};
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         win_valid <= 1'b0;
         win_out   <= '0;
         win_row   <= '0;
         win_col   <= '0;
      end else if (legal) begin
         win_valid <= 1'b0;
      end else if (emit) begin
         win_valid <= 1'b1;
         win_out   <= {pix_in, sr_bot[1], sr_bot[0],
                       lb0_rd, sr_mid[1], sr_mid[0],
                       lb1_rd, sr_top[1], sr_top[0]};
         win_row   <= row - DIM_BITS'(1);
         win_col   <= col - DIM_BITS'(1);
      end else if (win_ready) begin
         win_valid <= 1'b0;
      end
   end

`ifdef WINBUF_OVERRUN_CHECK_EN
   logic [7:0] stall_cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         overrun_err <= 1'b0;
         stall_cnt   <= '0;
      end else if (start) begin
         overrun_err <= 1'b0;
         stall_cnt   <= '0;
      end else begin
         if (win_valid && !win_ready) begin
            if (stall_cnt == 8'hFF) overrun_err <= 1'b1;
            else                    stall_cnt   <= stall_cnt + 8'd1;
         end else begin
            stall_cnt <= '0;
         end
         if (pix_valid && (state == FLUSH || state == DONE))
            overrun_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer; windows checked against a pixel formula.
// Also exercises overrun_err when WINBUF_OVERRUN_CHECK_EN is defined.
module tb_sobel_window_buffer;
   import edge_pkg::*;

   logic       clk;
   logic       n_rst;
   logic       start;
   logic [6:0] img_width;
   logic [6:0] img_height;
   logic [7:0] pix_in;
   logic       pix_valid;
   logic       pix_ready;
   window_t    win_out;
   logic       win_valid;
   logic       win_ready;
   logic [6:0] win_row;
   logic [6:0] win_col;
   logic       frame_done;
   logic       busy;
`ifdef WINBUF_OVERRUN_CHECK_EN
   logic       overrun_err;
`endif

   int checks = 0;
   int errors = 0;

   window_t cap [0:15];
   int      ncap;

   sobel_window_buffer dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .img_width  (img_width),
      .img_height (img_height),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .win_out    (win_out),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done),
      .busy       (busy)
`ifdef WINBUF_OVERRUN_CHECK_EN
      ,
      .overrun_err(overrun_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pix(input int r, input int c, input int m);
      return 8'(r * m + c);
   endfunction

   task automatic do_start(input int w, input int h);
      pix_valid  = 1'b0;
      start      = 1'b1;
      img_width  = 7'(w);
      img_height = 7'(h);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic feed_pixels(input int n, input int w, input int m,
                              output int nd);
      int cnt;
      cnt = 0;
      nd = 0;
      win_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && cnt < n; cyc++) begin
         pix_valid = 1'b1;
         pix_in = pix(cnt / w, cnt % w, m);
         @(negedge clk);
         if (pix_ready) cnt++;
         if (frame_done) nd++;
         @(posedge clk);
         #1;
      end
      pix_valid = 1'b0;
      checks++;
      if (cnt != n) begin
         errors++;
         $display("FAIL feed_count got %0d want %0d", cnt, n);
      end
   endtask

   task automatic run_frame(input int w, input int h, input int m,
                            input bit toggle);
      int      pidx, nwin, ndone, total, nexp, er, ec;
      window_t ew;
      total = w * h;
      nexp = (w - 2) * (h - 2);
      pidx = 0;
      nwin = 0;
      ndone = 0;
      ncap = 0;
      do_start(w, h);
      for (int cyc = 0; cyc < 4000 && ndone == 0; cyc++) begin
         pix_valid = (pidx < total);
         pix_in = pix(pidx / w, pidx % w, m);
         win_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
         @(negedge clk);
         if (win_valid) begin
            er = 1 + nwin / (w - 2);
            ec = 1 + nwin % (w - 2);
            for (int k = 0; k < 9; k++)
               ew[k] = pix(er - 1 + k / 3, ec - 1 + k % 3, m);
            checks++;
            if (nwin >= nexp || win_out !== ew
                || win_row !== 7'(er) || win_col !== 7'(ec)) begin
               errors++;
               $display("FAIL window%0d got %h r%0d c%0d want %h r%0d c%0d",
                        nwin, win_out, win_row, win_col, ew, er, ec);
            end
            if (win_ready) begin
               if (ncap < 16) cap[ncap] = win_out;
               ncap++;
               nwin++;
            end
         end
         if (pix_valid && pix_ready) pidx++;
         if (frame_done) ndone++;
         @(posedge clk);
         #1;
      end
      pix_valid = 1'b0;
      win_ready = 1'b1;
      checks++;
      if (ndone != 1) begin
         errors++;
         $display("FAIL frame_done_count got %0d want 1", ndone);
      end
      checks++;
      if (nwin != nexp) begin
         errors++;
         $display("FAIL window_count got %0d want %0d", nwin, nexp);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (frame_done !== 1'b0 || busy !== 1'b0 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_frame got done=%b busy=%b wv=%b want 0 0 0",
                     frame_done, busy, win_valid);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({pix_ready, win_valid, frame_done, busy} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000",
                  {pix_ready, win_valid, frame_done, busy});
      end
      checks++;
      if (win_out !== '0 || win_row !== 7'd0 || win_col !== 7'd0) begin
         errors++;
         $display("FAIL reset_window got %h r%0d c%0d want 0",
                  win_out, win_row, win_col);
      end
      @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   task automatic test_basic;
      window_t e0, e1;
      e0 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
      e1 = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
      run_frame(4, 3, 4, 1'b0);
      checks++;
      if (cap[0] !== e0) begin
         errors++;
         $display("FAIL basic_win0 got %h want %h", cap[0], e0);
      end
      checks++;
      if (cap[1] !== e1) begin
         errors++;
         $display("FAIL basic_win1 got %h want %h", cap[1], e1);
      end
   endtask

   task automatic test_stall;
      run_frame(5, 5, 16, 1'b1);
   endtask

   task automatic test_illegal;
      int ws [3];
      int hs [3];
      ws = '{2, 5, 65};
      hs = '{5, 2, 5};
      for (int t = 0; t < 3; t++) begin
         do_start(ws[t], hs[t]);
         pix_valid = 1'b1;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (pix_ready !== 1'b0 || busy !== 1'b0 || win_valid !== 1'b0) begin
               errors++;
               $display("FAIL illegal_dims w%0d h%0d got rdy=%b busy=%b want 0 0",
                        ws[t], hs[t], pix_ready, busy);
            end
            @(posedge clk);
            #1;
         end
         pix_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      int nd;
      do_start(4, 3);
      feed_pixels(7, 4, 4, nd);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy got %b want 1", busy);
      end
      #1;
      n_rst = 1'b0;
      #1;
      checks++;
      if ({pix_ready, win_valid, frame_done, busy} !== 4'b0
          || win_out !== '0 || win_row !== 7'd0 || win_col !== 7'd0) begin
         errors++;
         $display("FAIL mid_reset got %b %h want 0",
                  {pix_ready, win_valid, frame_done, busy}, win_out);
      end
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      run_frame(4, 3, 4, 1'b0);
   endtask

   task automatic test_abort;
      int nd;
      do_start(4, 3);
      feed_pixels(6, 4, 4, nd);
      checks++;
      if (nd != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre got done=%0d busy=%b want 0 1", nd, busy);
      end
      run_frame(5, 4, 16, 1'b0);
   endtask

`ifdef WINBUF_OVERRUN_CHECK_EN
   task automatic test_overrun;
      int nd;
      do_start(4, 3);
      feed_pixels(12, 4, 4, nd);
      pix_valid = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (overrun_err !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set got %b want 1", overrun_err);
      end
      pix_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (overrun_err !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky got %b want 1", overrun_err);
      end
      @(posedge clk);
      #1;
      do_start(4, 3);
      @(negedge clk);
      checks++;
      if (overrun_err !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear got %b want 0", overrun_err);
      end
   endtask
`endif

   initial begin
      n_rst      = 1'b0;
      start      = 1'b0;
      img_width  = '0;
      img_height = '0;
      pix_in     = '0;
      pix_valid  = 1'b0;
      win_ready  = 1'b1;
      ncap       = 0;
      for (int i = 0; i < 16; i++) cap[i] = '0;
      test_reset();
      test_basic();
      test_stall();
      test_illegal();
      test_reset_mid();
      test_abort();
`ifdef WINBUF_OVERRUN_CHECK_EN
      test_overrun();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
